// File: rtl/ma_ctrl_pkg.sv
// rtl/ma_ctrl_pkg.sv - shared states, accumulator codes and window helpers for ma_window_ctrl
package ma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SUB   = 3'd3,
    ST_ADD   = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2,
    ACC_CLR  = 2'd3
  } acc_op_t;

  localparam int SHIFT_BASE = 2;

  // Window length in samples for a 2-bit select: 4, 8, 16, 32.
  function automatic int unsigned window_len(input logic [1:0] cfg);
    return 32'd4 << cfg;
  endfunction

endpackage

// File: rtl/ma_strobe_sync.sv
// rtl/ma_strobe_sync.sv - strobe_in synchroniser with rising-edge detector
module ma_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Decoded from flops only; one cycle wide per synchronised rising edge.
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ma_window_ctrl.sv
// rtl/ma_window_ctrl.sv - moving-average sequencer; MA_CTRL_WARMUP_EN suppresses strobe_out until the window is full
module ma_window_ctrl
  import ma_ctrl_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_in,
  input  logic [1:0]        filter_select,
  output logic              sample_latch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [1:0]        acc_op,
  output logic [2:0]        shift_sel,
  output logic              strobe_out,
  output logic              busy,
  output logic              overrun,
  output logic              filled
);

  // DATA_W only sizes the datapath; the count width depends on ADDR_W alone.
  localparam int CntW  = (DATA_W > 0) ? ADDR_W + 1 : ADDR_W + 1;
  localparam int SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  state_t            state, state_nxt;
  acc_op_t           acc_nxt;
  logic [1:0]        cfg;
  logic [ADDR_W-1:0] wr_ptr, ptr_inc;
  logic [CntW-1:0]   count, count_inc, win_len, ptr_plus;
  logic              pend, pend_clr, edge_det, filled_now;
  logic              latch_nxt, we_nxt, out_nxt;

  ma_strobe_sync #(.SYNC_STAGES(SyncN)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe_in  (strobe_in),
    .edge_pulse (edge_det)
  );

  assign win_len    = CntW'(window_len(cfg));
  assign filled_now = (count == win_len);
  assign count_inc  = filled_now ? count : count + CntW'(1);
  assign ptr_plus   = CntW'(wr_ptr) + CntW'(1);
  assign ptr_inc    = (ptr_plus == win_len) ? '0 : ptr_plus[ADDR_W-1:0];
  assign ram_addr   = wr_ptr;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (filter_select != cfg) state_nxt = ST_FLUSH;
        else if (pend)            state_nxt = ST_LATCH;
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      ST_LATCH: state_nxt = ST_SUB;
      ST_SUB:   state_nxt = ST_ADD;
      ST_ADD:   state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so each
    // strobe is high exactly while the FSM sits in the matching state.
    latch_nxt = (state_nxt == ST_LATCH);
    we_nxt    = (state_nxt == ST_ADD);
    acc_nxt   = ACC_HOLD;
    unique case (state_nxt)
      ST_FLUSH: acc_nxt = ACC_CLR;
      ST_SUB:   acc_nxt = filled_now ? ACC_SUB : ACC_HOLD;
      ST_ADD:   acc_nxt = ACC_ADD;
      default:  acc_nxt = ACC_HOLD;
    endcase
`ifdef MA_CTRL_WARMUP_EN
    out_nxt = (state_nxt == ST_OUT) && (count_inc == win_len);
`else
    out_nxt = (state_nxt == ST_OUT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cfg          <= 2'd0;
      wr_ptr       <= '0;
      count        <= '0;
      sample_latch <= 1'b0;
      ram_we       <= 1'b0;
      acc_op       <= ACC_HOLD;
      shift_sel    <= 3'(SHIFT_BASE);
      strobe_out   <= 1'b0;
      busy         <= 1'b0;
      filled       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sample_latch <= latch_nxt;
      ram_we       <= we_nxt;
      acc_op       <= acc_nxt;
      strobe_out   <= out_nxt;
      busy         <= (state_nxt != ST_IDLE);
      if (state_nxt == ST_FLUSH) begin
        cfg       <= filter_select;
        shift_sel <= 3'(SHIFT_BASE) + {1'b0, filter_select};
        wr_ptr    <= '0;
        count     <= '0;
        filled    <= 1'b0;
      end else if (state == ST_OUT) begin
        wr_ptr <= ptr_inc;
        count  <= count_inc;
        filled <= (count_inc == win_len);
      end
    end
  end

  // One-deep edge queue; a new edge beats the LATCH clear in the same cycle.
  assign pend_clr = (state_nxt == ST_LATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (edge_det)      pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;

      if (state_nxt == ST_FLUSH)                overrun <= 1'b0;
      else if (edge_det && pend && !pend_clr)   overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ma_window_ctrl.sv
// tb/tb_ma_window_ctrl.sv - directed self-checking bench for ma_window_ctrl
module tb_ma_window_ctrl;

`ifdef MA_CTRL_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strobe_in = 1'b0;
  logic [1:0] filter_select = 2'd0;
  logic       sample_latch, ram_we, strobe_out, busy, overrun, filled;
  logic [4:0] ram_addr;
  logic [1:0] acc_op;
  logic [2:0] shift_sel;

  ma_window_ctrl #(.DATA_W(10), .ADDR_W(5), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .strobe_in     (strobe_in),
    .filter_select (filter_select),
    .sample_latch  (sample_latch),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .acc_op        (acc_op),
    .shift_sel     (shift_sel),
    .strobe_out    (strobe_out),
    .busy          (busy),
    .overrun       (overrun),
    .filled        (filled)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int addr_q[$];
  bit sub_q[$];
  bit sub_seen = 1'b0;
  int out_cnt = 0;
  int clr_cnt = 0;
  int out_at_clr = -1;

  // Event log per completed sample (address written, SUB seen before it).
  always @(negedge clk) begin
    if (acc_op == 2'd2) sub_seen = 1'b1;
    if (ram_we) begin
      addr_q.push_back(int'(ram_addr));
      sub_q.push_back(sub_seen);
      sub_seen = 1'b0;
    end
    if (strobe_out) out_cnt++;
    if (acc_op == 2'd3) begin
      clr_cnt++;
      out_at_clr = out_cnt;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    strobe_in = 1'b1;
    cyc(hi);
    strobe_in = 1'b0;
    cyc(lo);
  endtask

  task automatic wait_sig(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      cyc(1);
      ok = (sel == 0) ? ram_we : sample_latch;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sample_latch"}, sample_latch, 0);
    check({tag, " ram_addr"}, ram_addr, 0);
    check({tag, " ram_we"}, ram_we, 0);
    check({tag, " acc_op"}, acc_op, 0);
    check({tag, " shift_sel"}, shift_sel, 2);
    check({tag, " strobe_out"}, strobe_out, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " filled"}, filled, 0);
  endtask

  initial begin
    int base, o0, c0;
    bit ok;
    int exp_addr1[6] = '{0, 1, 2, 3, 0, 1};
    bit exp_sub1[6]  = '{0, 0, 0, 0, 1, 1};

    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(3);

    // Window of 4, six samples.
    base = addr_q.size();
    o0 = out_cnt;
    for (int e = 1; e <= 6; e++) begin
      pulse(3, 22);
      if (e == 3) check("t1 filled after 3", filled, 0);
      if (e == 4) check("t1 filled after 4", filled, 1);
    end
    check("t1 samples", addr_q.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1 addr %0d", i), (base + i < addr_q.size()) ? addr_q[base + i] : -1, exp_addr1[i]);
      check($sformatf("t1 sub %0d", i), (base + i < sub_q.size()) ? sub_q[base + i] : 1'b1, exp_sub1[i]);
    end
    check("t1 strobe_out count", out_cnt - o0, WARM ? 3 : 6);

    // filter_select changes while in ADD: flush only after OUT.
    strobe_in = 1'b1;
    wait_sig(0, 30, ok);
    check("t2 reached ADD", ok, 1);
    strobe_in = 1'b0;
    filter_select = 2'd2;
    o0 = out_cnt;
    c0 = clr_cnt;
    cyc(6);
    check("t2 clr count", clr_cnt - c0, 1);
    check("t2 out before clr", out_at_clr, o0 + 1);
    check("t2 shift_sel", shift_sel, 4);
    check("t2 ram_addr", ram_addr, 0);
    check("t2 filled", filled, 0);
    base = addr_q.size();
    for (int e = 0; e < 16; e++) pulse(2, 10);
    cyc(15);
    check("t2 samples", addr_q.size() - base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t2 addr %0d", i), (base + i < addr_q.size()) ? addr_q[base + i] : -1, i);
    check("t2 filled after 16", filled, 1);

    // Three edges two clocks apart: two samples, sticky overrun.
    check("t3 overrun before", overrun, 0);
    base = addr_q.size();
    pulse(1, 1);
    pulse(1, 1);
    pulse(1, 1);
    cyc(30);
    check("t3 samples", addr_q.size() - base, 2);
    check("t3 overrun set", overrun, 1);
    pulse(2, 20);
    check("t3 overrun sticky", overrun, 1);

    // Edge together with a select change in IDLE: flush first, no loss.
    base = addr_q.size();
    o0 = out_cnt;
    c0 = clr_cnt;
    filter_select = 2'd1;
    pulse(2, 25);
    check("t4 clr count", clr_cnt - c0, 1);
    check("t4 clr before out", out_at_clr, o0);
    check("t4 samples", addr_q.size() - base, 1);
    check("t4 addr", (addr_q.size() > base) ? addr_q[base] : -1, 0);
    check("t4 strobe_out count", out_cnt - o0, WARM ? 0 : 1);
    check("t4 overrun cleared", overrun, 0);
    check("t4 shift_sel", shift_sel, 3);

    // Reset asserted while in SUB.
    strobe_in = 1'b1;
    wait_sig(1, 30, ok);
    check("t5 reached LATCH", ok, 1);
    cyc(1);
    check("t5 in SUB busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5");
    strobe_in = 1'b0;
    filter_select = 2'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    base = addr_q.size();
    pulse(2, 20);
    check("t5 samples after release", addr_q.size() - base, 1);
    check("t5 first addr", (addr_q.size() > base) ? addr_q[base] : -1, 0);

    // Window of 32, forty samples: wrap and saturation.
    filter_select = 2'd3;
    cyc(4);
    check("t6 shift_sel", shift_sel, 5);
    base = addr_q.size();
    for (int e = 0; e < 40; e++) pulse(2, 10);
    cyc(15);
    check("t6 samples", addr_q.size() - base, 40);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("t6 addr %0d", i), (base + i < addr_q.size()) ? addr_q[base + i] : -1, i % 32);
      check($sformatf("t6 sub %0d", i), (base + i < sub_q.size()) ? sub_q[base + i] : 1'b0, (i >= 32) ? 1 : 0);
    end
    check("t6 filled", filled, 1);
    check("t6 ram_addr", ram_addr, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ma_window_ctrl.md
# ma_window_ctrl

Sequencer for the moving-average filter datapath. It synchronises the external sample strobe and steps a shared circular sample RAM and accumulator through one read-old / subtract / add-new / emit sequence per sample. It also tracks window fill and applies filter_select window-length changes safely between samples. It sits between the tt_um_moving_average_master pin interface and the accumulator/RAM datapath, and drives all of their control strobes.

## Interface
- DATA_W, 10, sample width; informational for the datapath, not used for control arithmetic
- ADDR_W, 5, RAM address width; maximum window is 2**ADDR_W = 32
- SYNC_STAGES, 2, flops in the strobe_in synchroniser, minimum 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- strobe_in  in  1  external sample strobe, asynchronous to clk; every rising edge marks one new sample
- filter_select  in  2  window select: 0→4, 1→8, 2→16, 3→32 samples
- sample_latch  out  1  datapath captures data_in into the new-sample register
- ram_addr  out  ADDR_W  circular buffer address, equal to wr_ptr
- ram_we  out  1  write the new sample at ram_addr
- acc_op  out  2  accumulator command: 0 HOLD, 1 ADD new, 2 SUB old, 3 CLR
- shift_sel  out  3  right-shift applied to the accumulator (log2 window), 2..5
- strobe_out  out  1  one-cycle pulse: filtered output is valid
- busy  out  1  FSM is not in IDLE
- overrun  out  1  sticky flag: a strobe edge was dropped
- filled  out  1  the window holds N valid samples

## Operation
- Edge detect: after SYNC_STAGES synchroniser flops, a rising edge sets `pend`. If an edge arrives while `pend` is already 1, set `overrun` and drop that edge. `pend` is a one-deep queue.
- Config register `cfg` (2 bits) updates only in IDLE. shift_sel = cfg+2. N = 4<<cfg.
- FSM states and transitions:
  - IDLE. If filter_select != cfg, go to FLUSH. Otherwise, if `pend` is set, go to LATCH. FLUSH has priority; `pend` is kept across FLUSH.
  - FLUSH. acc_op=CLR, cfg←filter_select, wr_ptr←0, count←0, overrun←0. Then go to IDLE.
  - LATCH. sample_latch=1, clear `pend`, RAM read of the oldest sample at wr_ptr.
  - SUB. acc_op=SUB if filled, else HOLD.
  - ADD. acc_op=ADD, ram_we=1.
  - OUT. strobe_out=1 (subject to Configuration). wr_ptr←(wr_ptr+1) mod N. count saturates at N. Then go to IDLE.
- filled = (count == N).
- wr_ptr wraps at N, not at 2**ADDR_W.
- count is ADDR_W+1 bits wide.
- Outside SUB, ADD and FLUSH, acc_op=HOLD.

## Timing
- Reset values: all outputs 0 except shift_sel=2. cfg=0, wr_ptr=0, count=0, `pend`=0, state IDLE.
- An asynchronous reset in mid-sequence aborts the sequence immediately. No partial RAM write survives; ram_we is registered and cleared.
- Latency: strobe_in rising edge to `pend`=1 is SYNC_STAGES+1 cycles. `pend` to strobe_out is 5 cycles (IDLE→LATCH→SUB→ADD→OUT), or 6 if a FLUSH precedes.
- Minimum strobe spacing without overrun: 5 clk per sample. A second edge may be queued while busy; a third overrruns.
- An edge arriving in the same cycle that LATCH clears `pend` is kept: the set wins over the clear.
- All outputs are registered Moore outputs with no combinational input-to-output path.

## Configuration
- MA_CTRL_WARMUP_EN defined: strobe_out is suppressed until filled=1. The first output appears on sample N.
- MA_CTRL_WARMUP_EN not defined: strobe_out pulses on every sample. During fill the output is the partial sum shifted by shift_sel.

## Structure
- Package ma_ctrl_pkg holds:
  - state enum (IDLE, FLUSH, LATCH, SUB, ADD, OUT)
  - acc_op codes
  - constant SHIFT_BASE=2
  - function window_len(cfg)
- Sub-module ma_strobe_sync contains the SYNC_STAGES synchroniser plus the rising-edge detector and outputs a one-cycle `edge` pulse.
- The FSM, pointers and overrun logic live in ma_window_ctrl.

## Test plan
- Reset, then filter_select=0, then 6 strobe edges spaced 25 clk apart. Required: ram_addr sequence 0,1,2,3,0,1. SUB issued only on edges 5 and 6. filled rises after edge 4. With MA_CTRL_WARMUP_EN, exactly 3 strobe_out pulses (samples 4, 5, 6).
- filter_select changed 0→2 while in ADD. Required: FLUSH occurs only after OUT, then shift_sel=4, wr_ptr=0, filled=0. The next 16 samples use addresses 0..15.
- Three edges spaced 2 clk apart. Required: 2 samples processed, overrun=1, which stays set until the next FLUSH or reset.
- Edge coincident with a filter_select change while in IDLE. Required: FLUSH first, then LATCH. No edge lost and overrun=0.
- rst_n asserted in SUB. Required: all outputs at their reset values immediately. The first sample after release writes address 0.
- filter_select=3 with 40 samples. Required: wr_ptr wraps 31→0, count saturates at 32, and every output after sample 32 has SUB asserted.
